// File: rtl/mod5_pkg.sv
// Shared constants for the modulo-5 counter.
package mod5_pkg;

   localparam int unsigned          MOD5_WIDTH     = 3;
   localparam logic [MOD5_WIDTH-1:0] MOD5_MAX       = 3'd4;
   localparam logic [MOD5_WIDTH-1:0] MOD5_RESET_VAL = 3'd0;

endpackage : mod5_pkg

// File: rtl/mod5_counter.sv
// Free-running modulo-5 counter, 0..4 then wrap, with a registered
// terminal-count flag that is high in the same cycle as q == 4.
module mod5_counter
   import mod5_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   output logic [MOD5_WIDTH-1:0] q,
   output logic                  tc
);

   logic [MOD5_WIDTH-1:0] q_next;
   logic                  tc_next;

   // Next count and next terminal flag; illegal codes 5..7 fall back to 0.
   always_comb begin
      q_next  = MOD5_RESET_VAL;
      tc_next = 1'b0;
      case (q)
         3'd0, 3'd1, 3'd2, 3'd3: begin
            q_next  = q + 3'd1;
            tc_next = (q_next == MOD5_MAX);
         end
         MOD5_MAX: begin
            q_next  = MOD5_RESET_VAL;
            tc_next = 1'b0;
         end
         default: begin
            q_next  = MOD5_RESET_VAL;
            tc_next = 1'b0;
         end
      endcase
   end

   // Count register; synchronous active-low reset takes priority over stepping.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q  <= MOD5_RESET_VAL;
         tc <= 1'b0;
      end else begin
         q  <= q_next;
         tc <= tc_next;
      end
   end

endmodule : mod5_counter

// File: tb/tb_mod5_counter.sv
// Directed, table-driven bench for mod5_counter.
module tb_mod5_counter;

   logic       clk;
   logic       reset;
   logic [2:0] q;
   logic       tc;

   int n_checks;
   int n_fail;

   typedef struct {
      logic       rst;
      logic [2:0] exp_q;
      logic       exp_tc;
   } vec_t;

   vec_t vecs [23];

   mod5_counter dut (
      .clk   (clk),
      .reset (reset),
      .q     (q),
      .tc    (tc)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step_and_check(input string name, input logic [2:0] eq, input logic et);
      @(posedge clk);
      @(negedge clk);
      check({name, " q"}, int'(q), int'(eq));
      check({name, " tc"}, int'(tc), int'(et));
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;

      // free run after release: 1,2,3,4,0,1,2,3,4,0,1,2
      vecs[0]  = '{1'b1, 3'd1, 1'b0};
      vecs[1]  = '{1'b1, 3'd2, 1'b0};
      vecs[2]  = '{1'b1, 3'd3, 1'b0};
      vecs[3]  = '{1'b1, 3'd4, 1'b1};
      vecs[4]  = '{1'b1, 3'd0, 1'b0};
      vecs[5]  = '{1'b1, 3'd1, 1'b0};
      vecs[6]  = '{1'b1, 3'd2, 1'b0};
      vecs[7]  = '{1'b1, 3'd3, 1'b0};
      vecs[8]  = '{1'b1, 3'd4, 1'b1};
      vecs[9]  = '{1'b1, 3'd0, 1'b0};
      vecs[10] = '{1'b1, 3'd1, 1'b0};
      vecs[11] = '{1'b1, 3'd2, 1'b0};
      // reset at q == 3, then release
      vecs[12] = '{1'b1, 3'd3, 1'b0};
      vecs[13] = '{1'b0, 3'd0, 1'b0};
      vecs[14] = '{1'b1, 3'd1, 1'b0};
      // reset held low for two edges stays at 0
      vecs[15] = '{1'b0, 3'd0, 1'b0};
      vecs[16] = '{1'b0, 3'd0, 1'b0};
      // count up to terminal, reset there, then resume
      vecs[17] = '{1'b1, 3'd1, 1'b0};
      vecs[18] = '{1'b1, 3'd2, 1'b0};
      vecs[19] = '{1'b1, 3'd3, 1'b0};
      vecs[20] = '{1'b1, 3'd4, 1'b1};
      vecs[21] = '{1'b0, 3'd0, 1'b0};
      vecs[22] = '{1'b1, 3'd1, 1'b0};

      // power-up reset on the first edge (10 ns), release at 15 ns
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("por q", int'(q), 0);
      check("por tc", int'(tc), 0);
      #4;
      reset = 1'b1;

      for (int i = 0; i < 23; i++) begin
         reset = vecs[i].rst;
         step_and_check($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_tc);
      end
      // now at a negedge with q == 1, reset high

      // short low pulse strictly between edges must be ignored
      #3 reset = 1'b0;
      #5 reset = 1'b1;
      step_and_check("sync pulse", 3'd2, 1'b0);
      step_and_check("sync pulse+1", 3'd3, 1'b0);
      step_and_check("pre-force", 3'd4, 1'b1);

      // illegal code recovery
      force dut.q = 3'd6;
      #1;
      release dut.q;
      step_and_check("recover", 3'd0, 1'b0);
      step_and_check("recover+1", 3'd1, 1'b0);
      step_and_check("recover+2", 3'd2, 1'b0);
      step_and_check("recover+3", 3'd3, 1'b0);
      step_and_check("recover+4", 3'd4, 1'b1);
      step_and_check("recover+5", 3'd0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mod5_counter
